// File: rtl/tt_um_enjimneering_full_adder.sv
// ---------------------------------------------------------------------------
// tt_um_enjimneering_full_adder
//
// Tiny Tapeout user tile holding a 1-bit full adder. The adder result is
// driven onto the dedicated outputs in two forms:
//   * directly from the adder, with no clock involved
//   * as a copy registered on the tile clock
//
// Ports:
//   clk      - tile clock; the registered copy updates on the rising edge
//   rst_n    - asynchronous, active-low reset; clears only the registered copy
//   ena      - harness enable; gates register updates only
//   ui_in    - [0]=a, [1]=b, [2]=cin, [7:3] ignored
//   uo_out   - [0]=sum, [1]=cout, [2]=sum_q, [3]=cout_q, [7:4]=0
//   uio_in   - ignored
//   uio_out  - constant 0
//   uio_oe   - constant 0, so the whole bidirectional bank stays as inputs
//
// The file also contains enjimneering_full_adder_cell, the reusable adder
// cell. The top tile instantiates it once.
// ---------------------------------------------------------------------------

module enjimneering_full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Majority function for the carry and 3-input parity for the sum.
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module tt_um_enjimneering_full_adder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic sum;
    logic cout;
    logic sum_q;
    logic cout_q;

    // The harness drives these pins, but the tile does not use them. The
    // reduction gives them a single sink, so the design reads them in
    // exactly one place. No output depends on this sink, so an X on these
    // pins cannot reach any output.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, ui_in[7:3], uio_in};

    enjimneering_full_adder_cell adder (
        .a    (ui_in[0]),
        .b    (ui_in[1]),
        .cin  (ui_in[2]),
        .sum  (sum),
        .cout (cout)
    );

    // Registered copy of the adder result. Reset is asynchronous, so the copy
    // clears as soon as rst_n falls. The first capture after reset is on the
    // first rising edge that sees rst_n high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= 1'b0;
            cout_q <= 1'b0;
        end else if (ena) begin
            sum_q  <= sum;
            cout_q <= cout;
        end
    end

    assign uo_out  = {4'b0000, cout_q, sum_q, cout, sum};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_enjimneering_full_adder.sv
// ---------------------------------------------------------------------------
// tb_tt_um_enjimneering_full_adder
//
// Directed bench for the full-adder tile. Each step drives the inputs, then
// compares the whole uo_out byte (and the uio bank) against a byte worked
// out by hand. Layout of uo_out: {0000, cout_q, sum_q, cout, sum}.
// ---------------------------------------------------------------------------

module tb_tt_um_enjimneering_full_adder;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int vectors;
    int miscompares;

    // Expected {cout,sum} for ui_in = 0..7, worked out by hand.
    logic [1:0] sweep_expected [8];

    tt_um_enjimneering_full_adder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net: if the bench stalls, report it and stop.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [7:0] ui, input logic [7:0] uio);
        ui_in  = ui;
        uio_in = uio;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        sweep_expected = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

        rst_n = 1'b0;
        ena   = 1'b0;
        applyStimulus(8'h00, 8'h00);
        #3;
        checkOutput("reset_uo_out", uo_out, 8'h00);
        checkOutput("reset_uio_out", uio_out, 8'h00);
        checkOutput("reset_uio_oe", uio_oe, 8'h00);

        // Sweep all eight input combinations while reset is held. This
        // drives uio_in to X, so the check also covers X-isolation.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(8'(i), 8'hxx);
            #20;
            checkOutput($sformatf("sweep_%0d", i), uo_out, {6'b000000, sweep_expected[i]});
            checkOutput($sformatf("sweep_oe_%0d", i), uio_oe, 8'h00);
        end

        applyStimulus(8'hF8, 8'h00);
        #20;
        checkOutput("upper_F8", uo_out, 8'h00);
        applyStimulus(8'hFF, 8'h00);
        #20;
        checkOutput("upper_FF", uo_out, 8'h03);
        applyStimulus(8'hFF, 8'hAA);
        #20;
        checkOutput("uio_AA", uo_out, 8'h03);
        checkOutput("uio_AA_out", uio_out, 8'h00);

        // Registered path: release reset between edges, then capture ui_in=3.
        @(negedge clk);
        rst_n = 1'b1;
        ena   = 1'b1;
        applyStimulus(8'h03, 8'h00);
        @(posedge clk);
        #1;
        checkOutput("capture_3", uo_out, 8'h0A);
        applyStimulus(8'h07, 8'h00);
        #2;
        checkOutput("midcycle_7", uo_out, 8'h0B);
        @(posedge clk);
        #1;
        checkOutput("capture_7", uo_out, 8'h0F);

        // Enable low: the registered copy holds 11 while the live path shows 00.
        ena = 1'b0;
        applyStimulus(8'h00, 8'h00);
        #1;
        checkOutput("hold_live", uo_out, 8'h0C);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("hold_clk_%0d", c), uo_out, 8'h0C);
        end

        // Re-capture 7, then assert reset between edges.
        ena = 1'b1;
        applyStimulus(8'h07, 8'h00);
        @(posedge clk);
        #1;
        checkOutput("recapture_7", uo_out, 8'h0F);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", uo_out, 8'h03);
        applyStimulus(8'h05, 8'h00);
        #1;
        checkOutput("reset_tracks", uo_out, 8'h02);
        @(posedge clk);
        #1;
        checkOutput("reset_ignores_clk", uo_out, 8'h02);

        // Release reset: the first rising edge captures ui_in=5 -> cout_q=1, sum_q=0.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("release_no_edge", uo_out, 8'h02);
        @(posedge clk);
        #1;
        checkOutput("release_capture_5", uo_out, 8'h0A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
